// File: rtl/decoder_buffer_req_seq_pkg.sv
// Shared types and constants for the bitstream buffer request sequencer.
// Holds the FSM state enum, the stride helper and the default FIFO/credit sizes.
`ifndef CORE_ADDRWIDTH
`define CORE_ADDRWIDTH 32
`endif

package decoder_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE,
      S_FLUSH
   } buf_seq_state_e;

   localparam int DEF_DMEM_DATA_WIDTH = 64;
   localparam int DEF_FIFO_DEPTH      = 8;
   localparam int DEF_MAX_OUTSTANDING = 4;

   function automatic int stride_bytes(input int dw);
      return dw / 8;
   endfunction

   localparam int DEF_STRIDE = stride_bytes(DEF_DMEM_DATA_WIDTH);

endpackage

// File: rtl/decoder_buffer_req_seq_if.sv
// Memory request/response and bitstream stream bundle of the sequencer.
// master: sequencer side (req valid/addr, bs valid/data out); slave: env side.
interface decoder_buffer_req_seq_if #(
   parameter int AW = 32,
   parameter int DW = 64
) ();

   logic          mem_req_valid_o;
   logic [AW-1:0] mem_req_addr_o;
   logic          mem_req_ready_i;
   logic          mem_rsp_valid_i;
   logic [DW-1:0] mem_rsp_data_i;
   logic          bs_valid_o;
   logic [DW-1:0] bs_data_o;
   logic          bs_ready_i;

   modport master (
      output mem_req_valid_o, mem_req_addr_o,
      output bs_valid_o, bs_data_o,
      input  mem_req_ready_i, mem_rsp_valid_i,
      input  mem_rsp_data_i, bs_ready_i
   );

   modport slave (
      input  mem_req_valid_o, mem_req_addr_o,
      input  bs_valid_o, bs_data_o,
      output mem_req_ready_i, mem_rsp_valid_i,
      output mem_rsp_data_i, bs_ready_i
   );

endinterface

// File: rtl/decoder_buf_fifo.sv
// Synchronous response FIFO; data visible the cycle after push, no bypass.
// Ports: push_i/data_i, pop_i/data_o, clear_i, full_o, empty_o, count_o.
module decoder_buf_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_cnt;
   logic             w_pop;
   logic             w_push;

   assign full_o  = (r_cnt == CW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign count_o = r_cnt;
   assign w_pop   = pop_i && !empty_o;
   // a pop in the same cycle frees the slot for a push when full
   assign w_push  = push_i && (!full_o || w_pop);
   assign data_o  = empty_o ? '0 : r_mem[r_rd];

   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wr] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PW'(1);
         if (w_pop)  r_rd <= r_rd + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && full_o && !w_pop && !clear_i));

endmodule

// File: rtl/decoder_buffer_req_seq.sv
// Walks [base, end) in dmem-word strides issuing credit-limited reads; data into a FIFO.
// Ports: start/flush/base/end in, bus (mem req/rsp, bs stream), cur_addr/busy/done/err out.
// Optional DECODER_BUF_REQ_PERF_EN adds perf_stall_cnt_o and perf_req_cnt_o.
`ifndef CORE_ADDRWIDTH
`define CORE_ADDRWIDTH 32
`endif

module decoder_buffer_req_seq
   import decoder_pkg::*;
#(
   parameter int dmem_data_width = DEF_DMEM_DATA_WIDTH,
   parameter int acc_addr_width  = `CORE_ADDRWIDTH,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic                      flush_i,
   input  logic [acc_addr_width-1:0] base_i,
   input  logic [acc_addr_width-1:0] end_i,
   decoder_buffer_req_seq_if.master  bus,
   output logic [acc_addr_width-1:0] cur_addr_o,
   output logic                      busy_o,
   output logic                      done_o,
`ifdef DECODER_BUF_REQ_PERF_EN
   output logic [31:0]               perf_stall_cnt_o,
   output logic [31:0]               perf_req_cnt_o,
`endif
   output logic                      err_o
);

   localparam int AW = acc_addr_width;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = ((OW > CW) ? OW : CW) + 1;
   localparam logic [AW-1:0] STEP = AW'(stride_bytes(dmem_data_width));
   localparam logic [AW-1:0] MASK = STEP - AW'(1);

   buf_seq_state_e r_state;
   buf_seq_state_e w_next;
   logic          r_start_q;
   logic          r_err;
   logic [AW-1:0] r_cur;
   logic [AW-1:0] r_end;
   logic [OW-1:0] r_out;
   logic          w_rise;
   logic          w_bad;
   logic          w_credit;
   logic          w_req_v;
   logic          w_hs;
   logic          w_rsp;
   logic          w_push;
   logic          w_pop;
   logic          w_clear;
   logic          w_full;
   logic          w_empty;
   logic          w_bs_valid;
   logic [CW-1:0] w_cnt;
   logic [SW-1:0] w_used;
   logic [AW-1:0] w_nxt_addr;

   assign w_rise     = start_i && !r_start_q;
   assign w_bad      = (|(base_i & MASK)) || (|(end_i & MASK))
                    || (end_i < base_i);
   // credits cover both in-flight reads and FIFO occupancy
   assign w_used     = SW'(r_out) + SW'(w_cnt);
   assign w_credit   = (r_out < OW'(MAX_OUTSTANDING))
                    && (w_used < SW'(FIFO_DEPTH));
   assign w_nxt_addr = r_cur + STEP;
   assign w_hs       = w_req_v && bus.mem_req_ready_i;
   // a response with nothing outstanding is ignored
   assign w_rsp      = bus.mem_rsp_valid_i && (r_out != '0);
   assign w_clear    = flush_i || (r_state == S_FLUSH);
   assign w_push     = w_rsp && !w_clear;
   assign w_bs_valid = !w_empty;
   assign w_pop      = w_bs_valid && bus.bs_ready_i;

   assign bus.mem_req_valid_o = w_req_v;
   assign bus.mem_req_addr_o  = r_cur;
   assign bus.bs_valid_o      = w_bs_valid;
   assign cur_addr_o          = r_cur;
   assign busy_o              = (r_state != S_IDLE);
   assign done_o              = (r_state == S_DONE);
   assign err_o               = r_err;

   always_comb begin
      w_next  = r_state;
      w_req_v = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_rise)
               w_next = (w_bad || base_i == end_i) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            w_req_v = w_credit;
            if (w_req_v && bus.mem_req_ready_i && w_nxt_addr == r_end)
               w_next = S_DRAIN;
         end
         S_DRAIN: if (r_out == '0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_FLUSH: if (r_out == '0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush_i && r_state != S_IDLE) begin
         w_next  = S_FLUSH;
         w_req_v = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         // track the level through reset so a held start cannot relaunch
         r_start_q <= start_i;
         r_err     <= 1'b0;
         r_cur     <= '0;
         r_end     <= '0;
         r_out     <= '0;
      end else begin
         r_state   <= w_next;
         r_start_q <= start_i;
         if (r_state == S_IDLE && w_rise) begin
            r_cur <= base_i;
            r_end <= end_i;
            r_err <= w_bad;
         end else if (w_hs) begin
            r_cur <= w_nxt_addr;
         end
         unique case ({w_hs, w_rsp})
            2'b10:   r_out <= r_out + OW'(1);
            2'b01:   r_out <= r_out - OW'(1);
            default: r_out <= r_out;
         endcase
      end
   end

   decoder_buf_fifo #(
      .WIDTH (dmem_data_width),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .data_i  (bus.mem_rsp_data_i),
      .pop_i   (w_pop),
      .clear_i (w_clear),
      .data_o  (bus.bs_data_o),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_cnt)
   );

`ifdef DECODER_BUF_REQ_PERF_EN
   logic [31:0] r_stall;
   logic [31:0] r_reqc;
   logic        w_stall;

   assign w_stall = (r_state == S_ISSUE) && !flush_i
                 && ((w_req_v && !bus.mem_req_ready_i) || !w_credit);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || (r_state == S_IDLE && w_rise)) begin
         r_stall <= '0;
         r_reqc  <= '0;
      end else begin
         if (w_stall && r_stall != '1) r_stall <= r_stall + 32'd1;
         if (w_hs && r_reqc != '1)     r_reqc  <= r_reqc + 32'd1;
      end
   end

   assign perf_stall_cnt_o = r_stall;
   assign perf_req_cnt_o   = r_reqc;
`endif

   a_rsp_proto: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.mem_rsp_valid_i && r_out == '0));

   a_fifo_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_decoder_buffer_req_seq.sv
// Directed bench for decoder_buffer_req_seq: fetch, credit, error, backpressure,
// flush and mid-run reset scenarios against a 3-edge-latency memory model.
module tb_decoder_buffer_req_seq;

   localparam int AW = 32;
   localparam int DW = 64;

   typedef struct {
      int            c;
      logic [AW-1:0] a;
   } pend_t;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic          flush_i;
   logic [AW-1:0] base_i;
   logic [AW-1:0] end_i;
   logic [AW-1:0] cur_addr_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_req = 0;
   int n_done = 0;
   int max_out = 0;
   int out_m = 0;
   int stab_err = 0;
   int done_cyc = 0;
   int last_rsp_cyc = 0;
   int lc = 0;
   bit rand_rdy = 1'b0;
   logic          prev_vnr = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [AW-1:0] req_log[$];
   logic [DW-1:0] pops[$];
   pend_t         pend[$];

   always #5 clk = ~clk;

   decoder_buffer_req_seq_if #(.AW(AW), .DW(DW)) bus ();

   decoder_buffer_req_seq #(
      .dmem_data_width (DW),
      .acc_addr_width  (AW),
      .FIFO_DEPTH      (8),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .flush_i    (flush_i),
      .base_i     (base_i),
      .end_i      (end_i),
      .bus        (bus),
      .cur_addr_o (cur_addr_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
      return {~a, a};
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst_ni) begin
         pend.delete();
         out_m = 0;
         prev_vnr = 1'b0;
      end else begin
         if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
            req_log.push_back(bus.mem_req_addr_o);
            pend.push_back('{c: cyc, a: bus.mem_req_addr_o});
            n_req++;
            out_m++;
         end
         if (bus.mem_rsp_valid_i) begin
            out_m--;
            last_rsp_cyc = cyc;
         end
         if (out_m > max_out) max_out = out_m;
         if (bus.bs_valid_o && bus.bs_ready_i) pops.push_back(bus.bs_data_o);
         if (done_o) begin
            n_done++;
            done_cyc = cyc;
         end
         if (prev_vnr && !flush_i &&
             !(bus.mem_req_valid_o && bus.mem_req_addr_o == prev_addr))
            stab_err++;
         prev_vnr  = bus.mem_req_valid_o && !bus.mem_req_ready_i;
         prev_addr = bus.mem_req_addr_o;
      end
   end

   always @(negedge clk) begin
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_data_i  = '0;
      if (rst_ni && pend.size() > 0 && pend[0].c + 2 <= cyc) begin
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rsp_data_i  = mk_data(pend[0].a);
         void'(pend.pop_front());
      end
      if (rand_rdy) bus.mem_req_ready_i = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_req = 0;
      n_done = 0;
      max_out = 0;
      stab_err = 0;
      done_cyc = 0;
      req_log.delete();
      pops.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] e);
      @(negedge clk);
      base_i  = b;
      end_i   = e;
      start_i = 1'b1;
      lc      = cyc;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (n_done == 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic chk_seq(input string tag, input logic [AW-1:0] b,
                          input int n);
      int ea = 0;
      int ed = 0;
      for (int i = 0; i < n; i++) begin
         if (i >= req_log.size() || req_log[i] !== b + AW'(8 * i)) ea++;
         if (i >= pops.size() || pops[i] !== mk_data(b + AW'(8 * i))) ed++;
      end
      chk({tag, "_nreq"}, 64'(n_req), 64'(n));
      chk({tag, "_addrs"}, 64'(ea), 64'd0);
      chk({tag, "_npops"}, 64'(pops.size()), 64'(n));
      chk({tag, "_data"}, 64'(ed), 64'd0);
   endtask

   initial begin
      int k;
      rst_ni = 1'b0;
      start_i = 1'b0;
      flush_i = 1'b0;
      base_i = '0;
      end_i = '0;
      bus.mem_req_ready_i = 1'b1;
      bus.bs_ready_i = 1'b1;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_data_i = '0;
      idle(3);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_cur", 64'(cur_addr_o), 64'd0);
      chk("rst_reqv", 64'(bus.mem_req_valid_o), 64'd0);
      chk("rst_addr", 64'(bus.mem_req_addr_o), 64'd0);
      chk("rst_bsv", 64'(bus.bs_valid_o), 64'd0);
      chk("rst_bsd", bus.bs_data_o, 64'd0);
      rst_ni = 1'b1;

      clr();
      launch(32'h1000, 32'h1040);
      wait_done("basic", 200);
      idle(5);
      chk_seq("basic", 32'h1000, 8);
      chk("basic_cur", 64'(cur_addr_o), 64'h1040);
      chk("basic_ndone", 64'(n_done), 64'd1);
      chk("basic_done_late", 64'(done_cyc > last_rsp_cyc), 64'd1);
      chk("basic_err", 64'(err_o), 64'd0);

      clr();
      launch(32'h2000, 32'h2000);
      wait_done("empty", 50);
      idle(2);
      chk("empty_nreq", 64'(n_req), 64'd0);
      chk("empty_err", 64'(err_o), 64'd0);
      chk("empty_lat", 64'(done_cyc - lc), 64'd2);
      chk("empty_ndone", 64'(n_done), 64'd1);

      clr();
      launch(32'h2004, 32'h2040);
      wait_done("mis", 50);
      idle(2);
      chk("mis_err", 64'(err_o), 64'd1);
      chk("mis_nreq", 64'(n_req), 64'd0);

      clr();
      launch(32'h3000, 32'h2000);
      wait_done("rev", 50);
      idle(2);
      chk("rev_err", 64'(err_o), 64'd1);
      chk("rev_nreq", 64'(n_req), 64'd0);

      clr();
      bus.bs_ready_i = 1'b0;
      launch(32'h3000, 32'h3080);
      idle(40);
      chk("cred_stall_nreq", 64'(n_req), 64'd8);
      chk("cred_bsv", 64'(bus.bs_valid_o), 64'd1);
      chk("cred_busy", 64'(busy_o), 64'd1);
      chk("cred_err_clr", 64'(err_o), 64'd0);
      bus.bs_ready_i = 1'b1;
      wait_done("cred", 300);
      idle(5);
      chk_seq("cred", 32'h3000, 16);
      chk("cred_maxout", 64'(max_out <= 4), 64'd1);
      chk("cred_cur", 64'(cur_addr_o), 64'h3080);

      clr();
      rand_rdy = 1'b1;
      launch(32'h4000, 32'h4100);
      wait_done("bp", 2000);
      rand_rdy = 1'b0;
      bus.mem_req_ready_i = 1'b1;
      idle(5);
      chk_seq("bp", 32'h4000, 32);
      chk("bp_stable", 64'(stab_err), 64'd0);
      chk("bp_maxout", 64'(max_out <= 4), 64'd1);

      clr();
      launch(32'h5000, 32'h5100);
      k = 0;
      while (n_req < 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("fl_out3", 64'(out_m), 64'd3);
      flush_i = 1'b1;
      #1;
      chk("fl_reqv_drop", 64'(bus.mem_req_valid_o), 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      start_i = 1'b0;
      idle(15);
      chk("fl_nreq", 64'(n_req), 64'd3);
      chk("fl_ndone", 64'(n_done), 64'd0);
      chk("fl_npops", 64'(pops.size()), 64'd0);
      chk("fl_busy", 64'(busy_o), 64'd0);
      chk("fl_bsv", 64'(bus.bs_valid_o), 64'd0);
      chk("fl_out0", 64'(out_m), 64'd0);

      clr();
      bus.bs_ready_i = 1'b0;
      launch(32'h6000, 32'h6010);
      wait_done("fi", 100);
      idle(3);
      chk("fi_bsv_full", 64'(bus.bs_valid_o), 64'd1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("fi_bsv_clr", 64'(bus.bs_valid_o), 64'd0);
      chk("fi_busy", 64'(busy_o), 64'd0);
      bus.bs_ready_i = 1'b1;
      idle(3);
      chk("fi_npops", 64'(pops.size()), 64'd0);

      clr();
      launch(32'h7000, 32'h7100);
      k = 0;
      while (n_req < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      rst_ni = 1'b0;
      @(negedge clk);
      chk("mr_reqv", 64'(bus.mem_req_valid_o), 64'd0);
      chk("mr_addr", 64'(bus.mem_req_addr_o), 64'd0);
      chk("mr_cur", 64'(cur_addr_o), 64'd0);
      chk("mr_busy", 64'(busy_o), 64'd0);
      chk("mr_bsv", 64'(bus.bs_valid_o), 64'd0);
      chk("mr_bsd", bus.bs_data_o, 64'd0);
      chk("mr_err", 64'(err_o), 64'd0);
      chk("mr_done", 64'(done_o), 64'd0);
      rst_ni = 1'b1;
      clr();
      idle(10);
      chk("mr_no_relaunch", 64'(n_req), 64'd0);
      chk("mr_idle", 64'(busy_o), 64'd0);

      start_i = 1'b0;
      clr();
      launch(32'h7000, 32'h7010);
      wait_done("rl", 100);
      idle(4);
      chk_seq("rl", 32'h7000, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_buffer_req_seq.md
Name: decoder_buffer_req_seq

Overview:
- Sequences bitstream buffer fetches for the H.264 decoder accelerator.
- While the RoCC interface holds buffer-request start, it walks the byte address range [base, end) in dmem-word strides and issues read requests to the LSU/dmem port, credit-limited.
- Read data returns in order into an internal FIFO that feeds the entropy decoder.
- The current request address is exported so the command interface can detect completion.

Parameters:
- dmem_data_width, 64, memory read data width in bits; stride = dmem_data_width/8 bytes.
- acc_addr_width, `CORE_ADDRWIDTH, byte address width.
- FIFO_DEPTH, 8, response FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 4, maximum issued-but-unreturned reads; must be <= FIFO_DEPTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- start_i  in  1  buffer request start level from the command interface
- flush_i  in  1  abort the current fetch and empty the FIFO
- base_i  in  acc_addr_width  buffer base byte address (regfile x0)
- end_i  in  acc_addr_width  buffer end byte address, exclusive (regfile x1)
- mem_req_valid_o  out  1  read request valid
- mem_req_addr_o  out  acc_addr_width  read byte address
- mem_req_ready_i  in  1  request accepted
- mem_rsp_valid_i  in  1  read data valid; in order, always accepted
- mem_rsp_data_i  in  dmem_data_width  read data
- bs_valid_o  out  1  FIFO head valid
- bs_data_o  out  dmem_data_width  FIFO head data
- bs_ready_i  in  1  decoder consumes the head
- cur_addr_o  out  acc_addr_width  next address to request; equals end_i after the last request is accepted
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the fetch completes
- err_o  out  1  sticky range error; cleared on the next accepted start

Behaviour:
- Reset (rst_ni low at a clk_i edge): state IDLE.
  - Counters and FIFO pointers cleared.
  - All outputs are 0: cur_addr_o, bs_data_o, mem_req_addr_o, err_o, and all valids.
- A response arriving in the cycle reset is applied is discarded.
- States: IDLE, ISSUE, DRAIN, DONE, FLUSH.
- IDLE:
  - On a start_i rising edge (registered previous value), latch base_i/end_i and set cur_addr = base.
  - If base or end is not stride-aligned, or end < base: set err_o and go to DONE with no requests.
  - If base == end: go to DONE.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req_valid_o = (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH).
  - mem_req_addr_o = cur_addr.
  - On a request handshake, cur_addr += stride.
  - When the accepted address + stride == end, go to DRAIN.
  - mem_req_valid_o is not dropped once asserted until the handshake, unless flush_i is asserted.
- DRAIN: no requests; when outstanding == 0, go to DONE.
- DONE: done_o = 1 for this one cycle, then IDLE.
  - The FIFO keeps its contents; the decoder continues draining.
- flush_i in any non-IDLE state has priority over every other transition:
  - Go to FLUSH; mem_req_valid_o deasserts the same cycle.
  - In FLUSH, responses are dropped and the FIFO is cleared.
  - When outstanding == 0, go to IDLE with no done_o.
  - flush_i in IDLE clears the FIFO only.
- Outstanding counter:
  - +1 on a request handshake, -1 on mem_rsp_valid_i; a simultaneous handshake and response leaves it unchanged.
  - A response with outstanding == 0 is a protocol error: ignored, plus an assertion.
- FIFO:
  - Push on mem_rsp_valid_i (outside FLUSH); pop on bs_valid_o && bs_ready_i.
  - Push and pop in the same cycle are allowed, including when full (the pop frees the slot).
  - Overflow is impossible by the credit rule; an assertion checks it.
  - Zero-cycle bypass is not allowed: data is visible on bs_data_o the cycle after the push.
- start_i held high after DONE does not restart; a new rising edge is required.
- Address arithmetic is modulo 2^acc_addr_width; wrap-around is not detected, because aligned end >= base is enforced.

Optional Feature:
- DECODER_BUF_REQ_PERF_EN
  - Defined: adds outputs perf_stall_cnt_o[31:0] and perf_req_cnt_o[31:0].
    - perf_stall_cnt_o counts ISSUE cycles with valid && !ready, or with credit exhausted.
    - perf_req_cnt_o counts accepted requests.
    - Both clear on an accepted start and saturate at all-ones.
  - Undefined: neither port nor the counters exist.

Decomposition:
- Shared package decoder_pkg holds:
  - buf_seq_state_e enum.
  - Stride localparam function of dmem_data_width.
  - Default FIFO_DEPTH and MAX_OUTSTANDING constants.
- One sub-module: decoder_buf_fifo, a synchronous FIFO.
  - Parameterised width/depth.
  - Ports: push, pop, clear, full, empty, count.
  - Same clock and synchronous active-low reset.

Test Plan:
- Basic fetch: base=0x1000, end=0x1040, mem_req_ready_i=1, response latency 3.
  - Exactly 8 requests at 0x1000..0x1038, in order.
  - cur_addr_o=0x1040 after the 8th; data pops out in order.
  - done_o pulses once after the last response.
- Credit limit: bs_ready_i=0, range of 16 words.
  - Issue stops after 8 requests (FIFO_DEPTH).
  - Releasing bs_ready_i resumes issue; outstanding never exceeds 4.
- Empty/error ranges:
  - base=end=0x2000 -> done_o one cycle after start, zero requests, err_o=0.
  - base=0x2004 -> err_o=1 and done_o, zero requests.
- Backpressure: mem_req_ready_i toggling randomly.
  - mem_req_addr_o stable while valid && !ready; no skipped or duplicate addresses.
- Flush: flush_i after 3 accepted requests with 3 outstanding.
  - No further requests; returning responses dropped; bs_valid_o=0.
  - Back to IDLE, done_o never asserted.
- Mid-operation reset: rst_ni low for one cycle during ISSUE.
  - All outputs 0 next cycle; start_i held high does not relaunch without a new rising edge.
